// File: rtl/ov_uart_pkg.sv
// Shared constants, state encoding and baud divider helper for the camera UART frame sender.
package ov_uart_pkg;

  localparam int unsigned CNT_W          = 17;
  localparam int unsigned PIX_W          = 16;
  localparam int unsigned IMAGE_SIZE_DEF = 76800;

  localparam logic [7:0] HDR0  = 8'h01;
  localparam logic [7:0] HDR1  = 8'hFE;
  localparam logic [7:0] TAIL0 = 8'hFE;
  localparam logic [7:0] TAIL1 = 8'h01;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_FETCH,
    ST_LATCH,
    ST_SEND_HI,
    ST_SEND_LO,
    ST_TAIL
  } state_t;

  // Rounded clock cycles per UART bit.
  function automatic int unsigned calc_div(input int unsigned clk_freq, input int unsigned baud);
    return (clk_freq + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/ov_uart_frame_tx_if.sv
// Read side of the capture-stage pixel FIFO (normal-mode, read clock supplied by the reader).
interface ov_uart_frame_tx_if;
  logic                           r_empty;
  logic [ov_uart_pkg::PIX_W-1:0]  r_data;
  logic                           r_req;
  logic                           r_clk;

  modport master (input r_empty, input r_data, output r_req, output r_clk);
  modport slave  (output r_empty, output r_data, input r_req, input r_clk);
endinterface

// File: rtl/uart_byte_tx.sv
// 8N1 byte transmitter with built-in baud divider; line idles high.
module uart_byte_tx
  import ov_uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 40000000,
  parameter int unsigned BAUD     = 921600
) (
  input  logic       S_CLK,
  input  logic       RST_N,
  input  logic       tx_start,
  input  logic [7:0] tx_byte,
  output logic       tx_busy,
  output logic       uart_txd
);

  localparam int unsigned DIV = calc_div(CLK_FREQ, BAUD);
  localparam int unsigned BCW = $clog2(DIV);

  logic [BCW-1:0] r_baud;
  logic [3:0]     r_bit;
  logic [9:0]     r_shift;
  logic           r_busy;
  logic           w_bit_end;

  assign w_bit_end = (r_baud == BCW'(DIV - 1));
  assign tx_busy   = r_busy;
  // Bit 0 of the shift register is the line itself, so reset forces the line high at once.
  assign uart_txd  = r_shift[0];

  always_ff @(posedge S_CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '1;
      r_busy  <= 1'b0;
    end else if (!r_busy) begin
      if (tx_start) begin
        r_shift <= {1'b1, tx_byte, 1'b0};
        r_baud  <= '0;
        r_bit   <= '0;
        r_busy  <= 1'b1;
      end
    end else if (w_bit_end) begin
      r_baud <= '0;
      if (r_bit == 4'd9) begin
        r_busy <= 1'b0;
      end else begin
        r_bit   <= r_bit + 4'd1;
        r_shift <= {1'b1, r_shift[9:1]};
      end
    end else begin
      r_baud <= r_baud + BCW'(1);
    end
  end

endmodule

// File: rtl/ov_uart_frame_tx.sv
// Drains the pixel FIFO and sends each frame as header, hi/lo pixel bytes and tail over UART.
module ov_uart_frame_tx
  import ov_uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 40000000,
  parameter int unsigned BAUD       = 921600,
  parameter int unsigned IMAGE_SIZE = IMAGE_SIZE_DEF
) (
  input  logic               S_CLK,
  input  logic               RST_N,
  input  logic               en,
  ov_uart_frame_tx_if.master fifo,
  output logic               uart_txd,
  output logic               busy,
  output logic               frame_done
);

  state_t           r_state;
  logic [1:0]       r_step;
  logic [CNT_W-1:0] r_cnt;
  logic [PIX_W-1:0] r_pix;
  logic             r_rd_req;
  logic             r_busy;
  logic             r_frame_done;
  logic             r_issued;

  logic             w_tx_busy;
  logic             w_tx_start;
  logic             w_free;
  logic [7:0]       w_tx_byte;
  logic [CNT_W-1:0] w_cnt_nxt;

  assign fifo.r_clk = ~S_CLK;
  assign fifo.r_req = r_rd_req;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;
  assign w_cnt_nxt  = r_cnt + CNT_W'(1);
  // Transmitter can take a byte: idle, and no start still in flight from last cycle.
  assign w_free     = !w_tx_busy && !r_issued;

  // Byte launch is decided in the same cycle the transmitter frees up, keeping inter-byte gaps to one cycle.
  always_comb begin
    w_tx_start = 1'b0;
    w_tx_byte  = 8'h00;
    case (r_state)
      ST_HDR: begin
        w_tx_start = w_free;
        w_tx_byte  = r_step[0] ? HDR1 : HDR0;
      end
      ST_SEND_HI: begin
        w_tx_start = w_free;
        w_tx_byte  = r_pix[15:8];
      end
      ST_SEND_LO: begin
        w_tx_start = w_free;
        w_tx_byte  = r_pix[7:0];
      end
      ST_TAIL: begin
        w_tx_start = w_free && (r_step != 2'd2);
        w_tx_byte  = r_step[0] ? TAIL1 : TAIL0;
      end
      default: ;
    endcase
  end

  // Frame sequencer; the next pixel is fetched while the previous low byte is still on the line.
  always_ff @(posedge S_CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state      <= ST_IDLE;
      r_step       <= '0;
      r_cnt        <= '0;
      r_pix        <= '0;
      r_rd_req     <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_issued     <= 1'b0;
    end else begin
      r_issued     <= w_tx_start;
      r_rd_req     <= 1'b0;
      r_frame_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_step <= '0;
          if (en) begin
            r_state <= ST_HDR;
            r_busy  <= 1'b1;
          end
        end
        ST_HDR: begin
          if (w_free) begin
            if (r_step[0]) begin
              r_step  <= '0;
              r_state <= ST_FETCH;
            end else begin
              r_step <= 2'd1;
            end
          end
        end
        ST_FETCH: begin
          if (!fifo.r_empty) begin
            r_rd_req <= 1'b1;
            r_state  <= ST_LATCH;
          end
        end
        // First cycle covers the request, second samples the FIFO output.
        ST_LATCH: begin
          if (r_step[0]) begin
            r_pix   <= fifo.r_data;
            r_step  <= '0;
            r_state <= ST_SEND_HI;
          end else begin
            r_step <= 2'd1;
          end
        end
        ST_SEND_HI: begin
          if (w_free) r_state <= ST_SEND_LO;
        end
        ST_SEND_LO: begin
          if (w_free) begin
            r_cnt   <= w_cnt_nxt;
            r_state <= (w_cnt_nxt == CNT_W'(IMAGE_SIZE)) ? ST_TAIL : ST_FETCH;
          end
        end
        ST_TAIL: begin
          if (w_free) begin
            if (r_step == 2'd2) begin
              r_frame_done <= 1'b1;
              r_busy       <= 1'b0;
              r_cnt        <= '0;
              r_step       <= '0;
              r_state      <= ST_IDLE;
            end else begin
              r_step <= r_step + 2'd1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  uart_byte_tx #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD)
  ) u_byte_tx (
    .S_CLK    (S_CLK),
    .RST_N    (RST_N),
    .tx_start (w_tx_start),
    .tx_byte  (w_tx_byte),
    .tx_busy  (w_tx_busy),
    .uart_txd (uart_txd)
  );

endmodule

// File: tb/tb_ov_uart_frame_tx.sv
// Scoreboard bench: a line decoder rebuilds UART bytes and checks them against queued frame expectations.
module tb_ov_uart_frame_tx;

  localparam int DIV    = 43;
  localparam int IMG    = 3;
  localparam int FLEN   = 4 + 2 * IMG;
  localparam int BYTE_T = 10 * DIV;

  logic S_CLK = 1'b0;
  logic RST_N = 1'b0;
  logic en    = 1'b0;
  logic uart_txd, busy, frame_done;

  ov_uart_frame_tx_if fif ();

  ov_uart_frame_tx #(.IMAGE_SIZE(IMG)) dut (
    .S_CLK      (S_CLK),
    .RST_N      (RST_N),
    .en         (en),
    .fifo       (fif),
    .uart_txd   (uart_txd),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 S_CLK = ~S_CLK;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  exp_q[$];
  logic [15:0] fifo_q[$];
  logic [15:0] push_q[$];

  int cyc = 0, last_start = 0, start_cnt = 0, byte_cnt = 0, fd_cnt = 0, req_cnt = 0;
  int byte_in_frame = 0, dec_cnt = 0, low_run = 0;
  bit dec_active = 0, low_open = 0, req_prev = 0, fd_prev = 0, gap_chk = 0;
  logic [7:0] dec_byte = 8'h00;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Normal-mode FIFO clocked on r_clk: a request pops and presents the word on the same r_clk edge.
  task automatic fifo_loop();
    forever begin
      @(posedge fif.r_clk);
      if (fif.r_req && fifo_q.size() > 0) fif.r_data = fifo_q.pop_front();
      while (push_q.size() > 0) fifo_q.push_back(push_q.pop_front());
      fif.r_empty = (fifo_q.size() == 0);
    end
  endtask

  // Samples the line once per cycle, decodes 8N1 bytes and scores them.
  task automatic monitor_loop();
    forever begin
      @(posedge S_CLK);
      #1;
      cyc++;
      if (fif.r_req) begin
        check("rreq_while_empty", int'(fif.r_empty), 0);
        check("rreq_double", int'(req_prev), 0);
        req_cnt++;
      end
      req_prev = fif.r_req;
      if (frame_done) begin
        fd_cnt++;
        check("fdone_busy", int'(busy), 0);
        check("fdone_double", int'(fd_prev), 0);
      end
      fd_prev = frame_done;
      if (!RST_N) begin
        dec_active    = 0;
        byte_in_frame = 0;
      end else if (!dec_active) begin
        if (uart_txd == 1'b0) begin
          dec_active = 1;
          dec_cnt    = 0;
          low_run    = 1;
          low_open   = 1;
          dec_byte   = 8'h00;
          start_cnt++;
          if (gap_chk && byte_in_frame != 0)
            check("byte_gap_ok", int'((cyc - last_start) >= BYTE_T && (cyc - last_start) <= BYTE_T + 1), 1);
          last_start = cyc;
        end
      end else begin
        dec_cnt++;
        if (low_open) begin
          if (uart_txd == 1'b0) low_run++;
          else low_open = 0;
        end
        if (dec_cnt == DIV / 2) begin
          check("start_mid", int'(uart_txd), 0);
        end else if (dec_cnt >= DIV + DIV / 2 && dec_cnt <= 8 * DIV + DIV / 2 &&
                     ((dec_cnt - DIV / 2) % DIV) == 0) begin
          dec_byte = {uart_txd, dec_byte[7:1]};
        end else if (dec_cnt == 9 * DIV + DIV / 2) begin
          check("stop_mid", int'(uart_txd), 1);
          if (dec_byte[0]) check("start_len", low_run, DIV);
          check("byte_expected", int'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) check("byte_value", int'(dec_byte), int'(exp_q.pop_front()));
          byte_in_frame = (byte_in_frame + 1) % FLEN;
          byte_cnt++;
          dec_active = 0;
        end
      end
    end
  endtask

  task automatic q_bytes(input logic [7:0] a, input logic [7:0] b);
    exp_q.push_back(a);
    exp_q.push_back(b);
  endtask

  task automatic add_pix(input logic [15:0] p, input bit load);
    q_bytes(p[15:8], p[7:0]);
    if (load) push_q.push_back(p);
  endtask

  task automatic step();
    @(posedge S_CLK);
    #2;
  endtask

  task automatic wait_busy();
    int n = 0;
    while (!busy && n < 200) begin step(); n++; end
    check("busy_rise", int'(busy), 1);
  endtask

  task automatic start_frame();
    en = 1'b1;
    wait_busy();
    en = 1'b0;
  endtask

  task automatic wait_fd(input int target);
    int n = 0;
    while (fd_cnt < target && n < 30000) begin step(); n++; end
    check("frame_done_count", fd_cnt, target);
  endtask

  task automatic end_of_frames(input int req_base, input int req_exp);
    step();
    check("exp_queue_drained", exp_q.size(), 0);
    check("rreq_pulses", req_cnt - req_base, req_exp);
    check("busy_after", int'(busy), 0);
  endtask

  initial begin
    int lows, act, rb, fb, sb, n;
    logic [15:0] p0, p1, p2, p3;
    fif.r_empty = 1'b1;
    fif.r_data  = 16'h0000;
    fork
      monitor_loop();
      fifo_loop();
    join_none

    // reset and quiet idle
    repeat (5) step();
    check("rst_txd", int'(uart_txd), 1);
    check("rst_rreq", int'(fif.r_req), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_fdone", int'(frame_done), 0);
    RST_N = 1'b1;
    lows = 0; act = 0;
    repeat (1000) begin
      step();
      if (!uart_txd) lows++;
      if (busy || fif.r_req || frame_done) act++;
    end
    check("idle_txd_low_cycles", lows, 0);
    check("idle_activity_cycles", act, 0);

    // preloaded frame including 0x55 bytes and A55A; en dropped mid-frame
    gap_chk = 1; rb = req_cnt; fb = fd_cnt;
    q_bytes(8'h01, 8'hFE);
    add_pix(16'h5555, 1);
    add_pix(16'hA55A, 1);
    add_pix(16'($urandom), 1);
    q_bytes(8'hFE, 8'h01);
    start_frame();
    wait_fd(fb + 1);
    end_of_frames(rb, IMG);

    // empty FIFO after the header, pixels arrive after a long stall
    gap_chk = 0; rb = req_cnt; fb = fd_cnt; sb = byte_cnt;
    p1 = 16'($urandom); p2 = 16'($urandom);
    q_bytes(8'h01, 8'hFE);
    add_pix(16'hBEEF, 0); add_pix(p1, 0); add_pix(p2, 0);
    q_bytes(8'hFE, 8'h01);
    start_frame();
    n = 0;
    while (byte_cnt < sb + 2 && n < 5000) begin step(); n++; end
    check("header_before_stall", byte_cnt - sb, 2);
    repeat (DIV) step();
    lows = 0; act = 0;
    repeat (5000) begin
      step();
      if (!uart_txd) lows++;
      if (fif.r_req || !busy) act++;
    end
    check("stall_txd_low_cycles", lows, 0);
    check("stall_rreq_or_idle", act, 0);
    push_q.push_back(16'hBEEF); push_q.push_back(p1); push_q.push_back(p2);
    wait_fd(fb + 1);
    end_of_frames(rb, IMG);

    // reset during data bit 4 of the first high byte
    gap_chk = 1; fb = fd_cnt; sb = start_cnt;
    p0 = 16'h0F00; p1 = 16'($urandom); p2 = 16'($urandom); p3 = 16'($urandom);
    q_bytes(8'h01, 8'hFE);
    add_pix(p0, 1); add_pix(p1, 1); add_pix(p2, 1);
    q_bytes(8'hFE, 8'h01);
    start_frame();
    n = 0;
    while (start_cnt < sb + 3 && n < 5000) begin step(); n++; end
    check("hi_byte_started", start_cnt - sb, 3);
    repeat (5 * DIV + DIV / 2) @(posedge S_CLK);
    #2;
    check("txd_bit4_low", int'(uart_txd), 0);
    RST_N = 1'b0;
    #1;
    check("txd_async_high", int'(uart_txd), 1);
    check("busy_async_low", int'(busy), 0);
    exp_q.delete();
    repeat (5) step();
    RST_N = 1'b1;
    check("pixels_left_in_fifo", fifo_q.size(), 2);
    rb = req_cnt;
    q_bytes(8'h01, 8'hFE);
    add_pix(p1, 0); add_pix(p2, 0); add_pix(p3, 1);
    q_bytes(8'hFE, 8'h01);
    start_frame();
    wait_fd(fb + 1);
    end_of_frames(rb, IMG);

    // two back-to-back frames with en held high
    gap_chk = 1; rb = req_cnt; fb = fd_cnt;
    for (int f = 0; f < 2; f++) begin
      q_bytes(8'h01, 8'hFE);
      for (int i = 0; i < IMG; i++) add_pix(16'($urandom), 1);
      q_bytes(8'hFE, 8'h01);
    end
    en = 1'b1;
    wait_fd(fb + 1);
    wait_busy();
    en = 1'b0;
    wait_fd(fb + 2);
    end_of_frames(rb, 2 * IMG);
    repeat (100) step();
    check("no_third_frame_busy", int'(busy), 0);
    check("no_third_frame_done", fd_cnt, fb + 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ov_uart_frame_tx.md
Name: ov_uart_frame_tx

Overview:
- Downstream consumer of the capture stage's 16-bit pixel FIFO (512 deep, RGB565, upper byte first).
- Pops pixels and serializes each one as two UART bytes, upper byte first.
- Wraps every frame of IMAGE_SIZE pixels in a 2-byte header and a 2-byte tail, so the PC viewer can lock onto frame boundaries.
- Contains the baud generator and the 8N1 transmitter.

Parameters:
- CLK_FREQ, 40000000, S_CLK frequency in Hz.
- BAUD, 921600, UART bit rate.
- IMAGE_SIZE, 76800, pixels per frame (240*320).
- HDR0 / HDR1, 8'h01 / 8'hFE, frame header bytes, in send order.
- TAIL0 / TAIL1, 8'hFE / 8'h01, frame tail bytes, in send order.

Ports:
- S_CLK  in  1  system clock.
- RST_N  in  1  asynchronous, active-low reset.
- en  in  1  permits starting a new frame; sampled only in IDLE.
- r_empty  in  1  pixel FIFO empty flag.
- r_data  in  16  FIFO read data; valid the cycle after r_req is high (normal-mode FIFO).
- r_req  out  1  FIFO read request, 1-cycle pulse per pixel.
- r_clk  out  1  FIFO read clock, equal to ~S_CLK.
- uart_txd  out  1  serial output, idle high.
- busy  out  1  high whenever the state is not IDLE.
- frame_done  out  1  1-cycle pulse after the last tail stop bit.

Behaviour:
- Reset values: r_req=0, uart_txd=1, busy=0, frame_done=0, pixel counter=0, state=IDLE, baud counter=0.
- Reset mid-byte: uart_txd returns high immediately (asynchronously) and the partial frame is abandoned. No resync byte is sent.
- Baud divider: DIV = (CLK_FREQ + BAUD/2) / BAUD, which is 43 at the defaults. Each bit lasts exactly DIV cycles.
- Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), so 10*DIV cycles per byte.
- Byte handshake to the sub-module: tx_start is a 1-cycle pulse carrying tx_byte. It is accepted only when tx_busy=0. tx_busy rises the cycle after tx_start and falls when the stop bit completes.
- Back-to-back bytes: the next tx_start is issued in the same cycle tx_busy falls is not required. One idle cycle between bytes is allowed; more than one is not.
- FSM states and transitions:
  - IDLE: if en=1, go to HDR.
  - HDR: send HDR0, then HDR1, then go to FETCH.
  - FETCH: if r_empty=0, pulse r_req and go to LATCH; otherwise stay in FETCH (stall, txd idle high).
  - LATCH: capture r_data into a 16-bit register, then go to SEND_HI.
  - SEND_HI: send reg[15:8], then go to SEND_LO.
  - SEND_LO: send reg[7:0] and increment the pixel counter. If the count now equals IMAGE_SIZE, go to TAIL; otherwise go to FETCH.
  - TAIL: send TAIL0, then TAIL1, pulse frame_done, clear the pixel counter, go to IDLE.
- r_req is never asserted while r_empty=1, and never twice without an intervening LATCH.
- The pixel counter is 17 bits wide (covers 76800) and is compared for equality only.
- en falling mid-frame has no effect; the current frame completes.
- Throughput: a pixel takes 20*DIV cycles (about 860 at the defaults). The FIFO is expected to fill, and the capture stage throttles on its almost-full count. This block must never lose or duplicate a pixel across an empty-FIFO stall.

Decomposition:
- Shared package ov_uart_pkg holds:
  - the DIV computation function;
  - the header and tail byte constants;
  - the IMAGE_SIZE default;
  - the FSM state localparams.
- Sub-module uart_byte_tx (ports: S_CLK, RST_N, tx_start, tx_byte[7:0], tx_busy, uart_txd) contains the baud counter, the 4-bit bit index and the 10-bit shift register.
- The top level holds only the FSM, the pixel counter and the FIFO handshake.

Test Plan:
- Reset: RST_N=0 for 5 cycles → uart_txd=1, r_req=0, busy=0; no activity for 1000 cycles with en=0.
- Bit timing: one byte 8'h55 → start-bit low exactly 43 cycles; bits sample 1,0,1,0,... at mid-bit; stop high 43 cycles.
- Small frame: IMAGE_SIZE=2, FIFO preloaded with 16'hA55A and 16'h1234, en=1 → decoded bytes 01 FE A5 5A 12 34 FE 01; exactly 2 r_req pulses; one frame_done pulse; busy then 0.
- Empty stall: FIFO empty after the header for 5000 cycles, then 16'hBEEF pushed → txd held high during the stall, then BE EF sent; r_req never high while r_empty=1.
- Reset mid-byte: assert RST_N during bit 4 of SEND_HI → uart_txd=1 the same cycle; after release with en=1, a fresh header 01 FE is sent first.
- Back-to-back frames: en held at 1, IMAGE_SIZE=3 → two complete frames; inter-byte gap ≤1 cycle whenever the FIFO is non-empty; pixel order preserved across frames.
